// File: rtl/pong_game_ctrl.sv
// Pong game controller: once per frame (vblank rising edge) moves ball and pads,
// resolves wall/pad collisions, keeps score and sequences serve/play/point/game-over.
module pong_game_ctrl #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int BALL_SIZE   = 15,
  parameter int PAD_HEIGHT  = 145,
  parameter int PAD_WIDTH   = 15,
  parameter int X_PAD_LEFT  = 30,
  parameter int X_PAD_RIGHT = 979,
  parameter int BALL_SPEED  = 4,
  parameter int PAD_SPEED   = 6,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       btn_up_l,
  input  logic       btn_dn_l,
  input  logic       btn_up_r,
  input  logic       btn_dn_r,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] y_pad_left,
  output logic [9:0] y_pad_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);

  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [9:0]  X_CENTRE   = 10'(H_ACTIVE / 2 - (BALL_SIZE + 1) / 2);
  localparam logic [9:0]  Y_CENTRE   = 10'(V_ACTIVE / 2 - (BALL_SIZE + 1) / 2);
  localparam logic [9:0]  PAD_CENTRE = 10'((V_ACTIVE - PAD_HEIGHT) / 2);
  localparam logic [9:0]  Y_BALL_MAX = 10'(V_ACTIVE - 1 - BALL_SIZE);
  localparam logic [9:0]  Y_PAD_MAX  = 10'(V_ACTIVE - 1 - PAD_HEIGHT);
  localparam logic [9:0]  X_HIT_L    = 10'(X_PAD_LEFT + PAD_WIDTH + 1);
  localparam logic [9:0]  X_HIT_R    = 10'(X_PAD_RIGHT - 1 - BALL_SIZE);
  localparam logic [9:0]  B_SPD      = 10'(BALL_SPEED);
  localparam logic [9:0]  P_SPD      = 10'(PAD_SPEED);
  localparam logic [10:0] W_B_SPD    = 11'(BALL_SPEED);
  localparam logic [10:0] W_SIZE     = 11'(BALL_SIZE);
  localparam logic [10:0] W_PAD_H    = 11'(PAD_HEIGHT);
  localparam logic [10:0] W_PAD_R    = 11'(X_PAD_RIGHT);
  localparam logic [10:0] W_X_MAX    = 11'(H_ACTIVE - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_DELAY);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t        state, state_nxt;
  logic [9:0]    x_nxt, y_nxt, pl_nxt, pr_nxt;
  logic [3:0]    sl_nxt, sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir_x, dir_x_nxt;   // 1 = right
  logic          dir_y, dir_y_nxt;   // 1 = down
  logic          scorer_l, scorer_l_nxt;
  logic          go_nxt;
  logic          vblnk_q, tick;
  logic [10:0]   bx, by;
  logic          overlap_l, overlap_r;

  function automatic logic [10:0] ext(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn)
      r = (y < P_SPD) ? '0 : y - P_SPD;
    else if (dn && !up)
      r = (ext(y) + ext(P_SPD) > ext(Y_PAD_MAX)) ? Y_PAD_MAX : y + P_SPD;
    return r;
  endfunction

  assign tick      = vblnk & ~vblnk_q;
  assign bx        = ext(x_ball);
  assign by        = ext(y_ball);
  assign overlap_l = (by + W_SIZE >= ext(y_pad_left))  && (by <= ext(y_pad_left) + W_PAD_H);
  assign overlap_r = (by + W_SIZE >= ext(y_pad_right)) && (by <= ext(y_pad_right) + W_PAD_H);

  always_comb begin
    state_nxt    = state;
    x_nxt        = x_ball;
    y_nxt        = y_ball;
    pl_nxt       = y_pad_left;
    pr_nxt       = y_pad_right;
    sl_nxt       = score_left;
    sr_nxt       = score_right;
    cnt_nxt      = cnt;
    dir_x_nxt    = dir_x;
    dir_y_nxt    = dir_y;
    scorer_l_nxt = scorer_l;
    if (tick) begin
      if (state inside {S_SERVE, S_PLAY, S_POINT}) begin
        pl_nxt = pad_step(y_pad_left, btn_up_l, btn_dn_l);
        pr_nxt = pad_step(y_pad_right, btn_up_r, btn_dn_r);
      end
      case (state)
        S_IDLE: begin
          x_nxt = X_CENTRE;
          y_nxt = Y_CENTRE;
          if (start) begin
            state_nxt = S_SERVE;
            cnt_nxt   = CNT_INIT;
          end
        end
        S_SERVE: begin
          x_nxt = X_CENTRE;
          y_nxt = Y_CENTRE;
          if (cnt <= CW'(1)) begin
            state_nxt = S_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_PLAY: begin
          // Vertical and horizontal axes resolve independently in the same tick.
          if (!dir_y) begin
            if (by < W_B_SPD) begin
              y_nxt     = '0;
              dir_y_nxt = 1'b1;
            end else begin
              y_nxt = y_ball - B_SPD;
            end
          end else if (by + W_B_SPD > ext(Y_BALL_MAX)) begin
            y_nxt     = Y_BALL_MAX;
            dir_y_nxt = 1'b0;
          end else begin
            y_nxt = y_ball + B_SPD;
          end
          if (!dir_x) begin
            if (bx >= ext(X_HIT_L) && bx - W_B_SPD <= ext(X_HIT_L) - 11'd1 && overlap_l) begin
              x_nxt     = X_HIT_L;
              dir_x_nxt = 1'b1;
            end else if (bx < W_B_SPD) begin
              sr_nxt       = (score_right < WIN) ? score_right + 4'd1 : score_right;
              scorer_l_nxt = 1'b0;
              state_nxt    = S_POINT;
            end else begin
              x_nxt = x_ball - B_SPD;
            end
          end else begin
            if (bx + W_SIZE <= W_PAD_R - 11'd1 && bx + W_SIZE + W_B_SPD >= W_PAD_R && overlap_r) begin
              x_nxt     = X_HIT_R;
              dir_x_nxt = 1'b0;
            end else if (bx + W_SIZE + W_B_SPD > W_X_MAX) begin
              sl_nxt       = (score_left < WIN) ? score_left + 4'd1 : score_left;
              scorer_l_nxt = 1'b1;
              state_nxt    = S_POINT;
            end else begin
              x_nxt = x_ball + B_SPD;
            end
          end
        end
        S_POINT: begin
          x_nxt = X_CENTRE;
          y_nxt = Y_CENTRE;
          if (scorer_l ? (score_left == WIN) : (score_right == WIN)) begin
            state_nxt = S_OVER;
          end else begin
            state_nxt = S_SERVE;
            cnt_nxt   = CNT_INIT;
            dir_x_nxt = scorer_l;  // serve toward the player who conceded
          end
        end
        S_OVER: begin
          x_nxt = X_CENTRE;
          y_nxt = Y_CENTRE;
          if (start) begin
            sl_nxt    = '0;
            sr_nxt    = '0;
            pl_nxt    = PAD_CENTRE;
            pr_nxt    = PAD_CENTRE;
            state_nxt = S_SERVE;
            cnt_nxt   = CNT_INIT;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    go_nxt = (state_nxt == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      x_ball      <= X_CENTRE;
      y_ball      <= Y_CENTRE;
      y_pad_left  <= PAD_CENTRE;
      y_pad_right <= PAD_CENTRE;
      score_left  <= '0;
      score_right <= '0;
      game_over   <= 1'b0;
      cnt         <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      scorer_l    <= 1'b0;
      vblnk_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      x_ball      <= x_nxt;
      y_ball      <= y_nxt;
      y_pad_left  <= pl_nxt;
      y_pad_right <= pr_nxt;
      score_left  <= sl_nxt;
      score_right <= sr_nxt;
      game_over   <= go_nxt;
      cnt         <= cnt_nxt;
      dir_x       <= dir_x_nxt;
      dir_y       <= dir_y_nxt;
      scorer_l    <= scorer_l_nxt;
      vblnk_q     <= vblnk;
    end
  end

endmodule
